// File: rtl/mul4_seq_pkg.sv
// mul4_seq_pkg: shared types and constants for the 4x4 multiplier sequencer.
//   state_t        sequencer FSM states
//   OP_W / P_W     default operand / product widths of the multiplier
//   wdog_w()       watchdog counter width for a given timeout
package mul4_seq_pkg;

    localparam int OP_W            = 4;
    localparam int P_W             = 2 * OP_W;
    localparam int DEF_TIMEOUT_CYC = 16;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int wdog_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int WDOG_W = wdog_w(DEF_TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_LO,
        WAIT_HI,
        HOLD
    } state_t;

endpackage

// File: rtl/mul4_seq_wdog.sv
// mul4_seq_wdog: clearable, enable-gated up-counter with a terminal-count flag.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset (count -> 0)
//   clr  in   synchronous clear (count -> 0)
//   en   in   count enable
//   tc   out  count equals TC
module mul4_seq_wdog
    import mul4_seq_pkg::*;
#(
    parameter int W  = WDOG_W,
    parameter int TC = DEF_TIMEOUT_CYC - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == W'(TC));

endmodule

// File: rtl/mul4_op_sequencer.sv
// mul4_op_sequencer: issues operand pairs to a 4x4 shift-add multiplier
// (START/A/B/READY/P) and returns products on a valid/ready stream.
// One operation in flight at a time; a watchdog aborts operations whose
// READY never completes its low-then-high cycle.
//
// Optional feature: define MUL4_ACCUM_EN to accumulate products into an
// ACC_W-bit running sum (cleared by RST or by IN_CLR sent with a pair).
//
// Ports:
//   CK, RST                   clock, synchronous active-high reset
//   IN_VALID/IN_READY         operand handshake; IN_A, IN_B, IN_CLR payload
//   MUL_START, MUL_A, MUL_B   drive to the multiplier
//   MUL_READY, MUL_P          status / product from the multiplier
//   OUT_VALID/OUT_READY       result handshake; OUT_P, OUT_TIMEOUT payload
//   BUSY                      operation in progress
module mul4_op_sequencer #(
    parameter int OP_W        = mul4_seq_pkg::OP_W,
    parameter int P_W         = mul4_seq_pkg::P_W,
    parameter int ACC_W       = 12,
    parameter int TIMEOUT_CYC = mul4_seq_pkg::DEF_TIMEOUT_CYC,
`ifdef MUL4_ACCUM_EN
    localparam int OUT_W      = ACC_W
`else
    localparam int OUT_W      = P_W
`endif
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [OP_W-1:0]  IN_A,
    input  logic [OP_W-1:0]  IN_B,
    input  logic             IN_CLR,
    output logic             MUL_START,
    output logic [OP_W-1:0]  MUL_A,
    output logic [OP_W-1:0]  MUL_B,
    input  logic             MUL_READY,
    input  logic [P_W-1:0]   MUL_P,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [OUT_W-1:0] OUT_P,
    output logic             OUT_TIMEOUT,
    output logic             BUSY
);
    import mul4_seq_pkg::*;

    localparam int WD_W = wdog_w(TIMEOUT_CYC);

    state_t state, state_nxt;
    logic   waiting, wd_tc, done, expire;

    assign waiting = (state == WAIT_LO) || (state == WAIT_HI);
    // Completion beats a watchdog expiry landing on the same cycle.
    assign done    = (state == WAIT_HI) && MUL_READY;
    assign expire  = waiting && wd_tc && !done;

    mul4_seq_wdog #(
        .W  (WD_W),
        .TC (TIMEOUT_CYC - 1)
    ) u_wdog (
        .clk (CK),
        .rst (RST),
        .clr (state == LAUNCH),
        .en  (waiting),
        .tc  (wd_tc)
    );

    always_ff @(posedge CK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (IN_VALID) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT_LO;
            // READY low proves the multiplier picked up this START, which
            // also resynchronises after a reset that left it mid-run.
            WAIT_LO: if (expire) state_nxt = HOLD;
                     else if (!MUL_READY) state_nxt = WAIT_HI;
            WAIT_HI: if (done || expire) state_nxt = HOLD;
            HOLD:    if (OUT_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign IN_READY  = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign MUL_START = (state == LAUNCH) && !RST;

`ifdef MUL4_ACCUM_EN
    logic             clr_q;
    logic [ACC_W-1:0] acc, sum;
    assign sum = (clr_q ? '0 : acc) + ACC_W'(MUL_P);
`else
    wire unused_clr = IN_CLR;
`endif

    always_ff @(posedge CK) begin
        if (RST) begin
            MUL_A       <= '0;
            MUL_B       <= '0;
            OUT_VALID   <= 1'b0;
            OUT_P       <= '0;
            OUT_TIMEOUT <= 1'b0;
`ifdef MUL4_ACCUM_EN
            clr_q       <= 1'b0;
            acc         <= '0;
`endif
        end else begin
            if (state == IDLE && IN_VALID) begin
                MUL_A <= IN_A;
                MUL_B <= IN_B;
`ifdef MUL4_ACCUM_EN
                clr_q <= IN_CLR;
`endif
            end
            if (done) begin
                OUT_VALID   <= 1'b1;
                OUT_TIMEOUT <= 1'b0;
`ifdef MUL4_ACCUM_EN
                OUT_P       <= sum;
                acc         <= sum;
`else
                OUT_P       <= MUL_P;
`endif
            end else if (expire) begin
                // Aborted result: zero payload, accumulator untouched.
                OUT_VALID   <= 1'b1;
                OUT_TIMEOUT <= 1'b1;
                OUT_P       <= '0;
            end else if (state == HOLD && OUT_READY) begin
                OUT_VALID   <= 1'b0;
            end
        end
    end

endmodule
